// File: rtl/button_pkg.sv
// Shared types and 12 MHz timing defaults for the push-button conditioning chain.
package button_pkg;

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StArmPress   = 2'd1,
        StPressed    = 2'd2,
        StArmRelease = 2'd3
    } btn_state_t;

    localparam int unsigned DEB_10MS = 120000;
    localparam int unsigned HOLD_1S  = 12000000;

    // Width able to hold the value n itself, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pad input; reset loads RESET_VAL.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronizer, debounce counter and 4-state FSM producing level/strobes.
// Long-press detection is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS,
    parameter int unsigned LONG_CYCLES     = HOLD_1S,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    output logic             level_o,
    output logic             press_o,
    output logic             release_o,
    output logic             long_o,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned   CW      = cnt_width(LONG_CYCLES);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);

    logic s_sync;
    logic s_act;

    btn_state_t state_q, state_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic level_q, level_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Reset value is the idle pad level so no phantom press appears after reset.
    sync_2ff #(
        .RESET_VAL(ACTIVE_LOW)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_raw),
        .q  (s_sync)
    );

    assign s_act = s_sync ^ ACTIVE_LOW;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] LONG_PRE = CW'(LONG_CYCLES - 1);

    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic long_q, long_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
        end
    end

    // Saturating hold counter; frozen outside PRESSED so a bounce cannot re-arm long_o.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;
        if (press_d) begin
            hold_cnt_d = '0;
        end else if (state_q == StPressed && hold_cnt_q != LONG_MAX) begin
            hold_cnt_d = hold_cnt_q + CW'(1);
            long_d     = (hold_cnt_q == LONG_PRE);
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    // Next-state and debounce counter
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (s_act) begin
                    state_d  = StArmPress;
                    db_cnt_d = CW'(1);
                end
            end
            StArmPress: begin
                if (!s_act) begin
                    state_d = StIdle;
                end else if (db_cnt_q == DEB_MAX) begin
                    state_d = StPressed;
                end else begin
                    db_cnt_d = db_cnt_q + CW'(1);
                end
            end
            StPressed: begin
                if (!s_act) begin
                    state_d  = StArmRelease;
                    db_cnt_d = CW'(1);
                end
            end
            StArmRelease: begin
                if (s_act) begin
                    state_d = StPressed;
                end else if (db_cnt_q == DEB_MAX) begin
                    state_d = StIdle;
                end else begin
                    db_cnt_d = db_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobe, level and press-count next values
    always_comb begin
        press_d   = (state_q == StArmPress) && s_act && (db_cnt_q == DEB_MAX);
        release_d = (state_q == StArmRelease) && !s_act && (db_cnt_q == DEB_MAX);
        level_d   = level_q;
        if (press_d) begin
            level_d = 1'b1;
        end else if (release_d) begin
            level_d = 1'b0;
        end
        count_d = count_q + CNT_W'(press_d);
    end

    assign level_o     = level_q;
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign press_count = count_q;

endmodule
